// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of the single-port data memory: CPU has fixed
// priority, DMA gets a starvation guard, and 1-cycle read data is routed back to its issuer.
module data_mem_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_memread,
    input  logic        cpu_memwrite,
    input  logic [3:0]  cpu_sign_mask,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,
    output logic        cpu_stall,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic        dma_memread,
    input  logic        dma_memwrite,
    input  logic [3:0]  dma_sign_mask,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_memread,
    output logic        mem_memwrite,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        logic [3:0]  sign_mask;
    } mem_req_t;

    mem_req_t      cpu_r, dma_r, mem_r;
    logic          cpu_req, dma_req;
    logic          cpu_win, dma_win;
    logic          starved;
    logic [WW-1:0] wait_cnt;
    logic [1:0]    rd_owner;  // [1] = CPU, [0] = DMA

    // Read beats write when both are raised, matching data_mem.
    always_comb begin
        cpu_r = '{addr: cpu_addr, wdata: cpu_wdata, rd: cpu_memread,
                  wr: cpu_memwrite & ~cpu_memread, sign_mask: cpu_sign_mask};
        dma_r = '{addr: dma_addr, wdata: dma_wdata, rd: dma_memread,
                  wr: dma_memwrite & ~dma_memread, sign_mask: dma_sign_mask};
    end

    assign cpu_req = cpu_memread | cpu_memwrite;
    assign dma_req = dma_memread | dma_memwrite;
    assign starved = (wait_cnt == WAIT_MAX);

    always_comb begin
        cpu_win = 1'b0;
        dma_win = 1'b0;
        if (rst_n) begin
            if (dma_req && (!cpu_req || starved))
                dma_win = 1'b1;
            else if (cpu_req)
                cpu_win = 1'b1;
        end
    end

    always_comb begin
        mem_r = '0;
        if (cpu_win)
            mem_r = cpu_r;
        else if (dma_win)
            mem_r = dma_r;
    end

    assign mem_addr      = mem_r.addr;
    assign mem_wdata     = mem_r.wdata;
    assign mem_memread   = mem_r.rd;
    assign mem_memwrite  = mem_r.wr;
    assign mem_sign_mask = mem_r.sign_mask;

    assign cpu_stall = cpu_req & ~cpu_win & rst_n;
    assign dma_gnt   = dma_win;

    // Consecutive DMA losses; saturates so the guard stays armed until DMA wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (dma_req && !dma_win)
            wait_cnt <= starved ? wait_cnt : wait_cnt + WW'(1);
        else
            wait_cnt <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_owner <= 2'b00;
        else
            rd_owner <= {cpu_win & cpu_memread, dma_win & dma_memread};
    end

    assign cpu_rvalid = rd_owner[1];
    assign dma_rvalid = rd_owner[0];
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : 32'h0;
    assign dma_rdata  = dma_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small behavioural data_mem behind it.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_memread, cpu_memwrite, cpu_rvalid, cpu_stall;
    logic [3:0]  cpu_sign_mask;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_memread, dma_memwrite, dma_gnt, dma_rvalid;
    logic [3:0]  dma_sign_mask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_memread, mem_memwrite;
    logic [3:0]  mem_sign_mask;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:4095];

    data_mem_arbiter #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_memread(cpu_memread),
        .cpu_memwrite(cpu_memwrite), .cpu_sign_mask(cpu_sign_mask),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_memread(dma_memread),
        .dma_memwrite(dma_memwrite), .dma_sign_mask(dma_sign_mask),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_sign_mask(mem_sign_mask),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // data_mem model: little-endian sub-word writes, 1-cycle word reads, contents preloaded in reset
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[12'h400] <= 32'hDEADBEEF;
            mem[12'h401] <= 32'h11223344;
            mem[12'h402] <= 32'h55AA55AA;
        end else if (mem_memwrite) begin
            case (mem_sign_mask)
                4'b0001: mem[mem_addr[13:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
                4'b0011: mem[mem_addr[13:2]][16*mem_addr[1] +: 16] <= mem_wdata[15:0];
                default: mem[mem_addr[13:2]] <= mem_wdata;
            endcase
        end
        if (mem_memread)
            mem_rdata <= mem[mem_addr[13:2]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_addr = '0; cpu_wdata = '0; cpu_memread = 0; cpu_memwrite = 0; cpu_sign_mask = '0;
        dma_addr = '0; dma_wdata = '0; dma_memread = 0; dma_memwrite = 0; dma_sign_mask = '0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        cpu_memread = 1; cpu_addr = 32'h1000;
        dma_memread = 1; dma_addr = 32'h1008;
        #2;
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", cpu_stall); end
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL rst_dma_gnt got=%b exp=0", dma_gnt); end
        checks++; if (mem_memread !== 1'b0) begin errors++; $display("FAIL rst_memread got=%b exp=0", mem_memread); end
        checks++; if ({cpu_rvalid, dma_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got=%b exp=00", {cpu_rvalid, dma_rvalid}); end
        step(); step();
        idle();
        rst_n = 1;
    endtask

    task automatic test_cpu_read();
        step();
        cpu_memread = 1; cpu_addr = 32'h1000; cpu_sign_mask = 4'b0111;
        #1;
        checks++; if (mem_memread !== 1'b1) begin errors++; $display("FAIL t1_memread got=%b exp=1", mem_memread); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL t1_stall got=%b exp=0", cpu_stall); end
        checks++; if ({mem_addr, mem_sign_mask} !== {32'h1000, 4'b0111}) begin errors++; $display("FAIL t1_mux got=%h/%b exp=00001000/0111", mem_addr, mem_sign_mask); end
        step();
        idle();
        #1;
        checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL t1_rvalid got=%b exp=1", cpu_rvalid); end
        checks++; if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_rdata got=%h exp=deadbeef", cpu_rdata); end
        checks++; if ({dma_rvalid, dma_rdata} !== 33'h0) begin errors++; $display("FAIL t1_dma_quiet got=%b/%h exp=0/0", dma_rvalid, dma_rdata); end
        checks++; if ({mem_addr, mem_memread, mem_memwrite} !== 34'h0) begin errors++; $display("FAIL t1_idle_mux got=%h exp=0", mem_addr); end
    endtask

    task automatic test_starvation();
        logic prev_dma = 0;
        logic exp_dma;
        for (int c = 0; c <= 10; c++) begin
            step();
            if (c < 10) begin
                cpu_memread = 1; cpu_addr = 32'h1000; cpu_sign_mask = 4'b0111;
                dma_memread = 1; dma_addr = 32'h1008; dma_sign_mask = 4'b0111;
            end else idle();
            #1;
            exp_dma = (c == 4 || c == 9);
            if (c < 10) begin
                checks++; if (dma_gnt !== exp_dma) begin errors++; $display("FAIL t2_gnt c=%0d got=%b exp=%b", c, dma_gnt, exp_dma); end
                checks++; if (cpu_stall !== exp_dma) begin errors++; $display("FAIL t2_stall c=%0d got=%b exp=%b", c, cpu_stall, exp_dma); end
                checks++; if (mem_addr !== (exp_dma ? 32'h1008 : 32'h1000)) begin errors++; $display("FAIL t2_addr c=%0d got=%h", c, mem_addr); end
            end
            if (c > 0) begin
                checks++; if ({cpu_rvalid, dma_rvalid} !== {~prev_dma, prev_dma}) begin errors++; $display("FAIL t2_rvalid c=%0d got=%b exp=%b", c, {cpu_rvalid, dma_rvalid}, {~prev_dma, prev_dma}); end
                checks++; if (cpu_rdata !== (prev_dma ? 32'h0 : 32'hDEADBEEF)) begin errors++; $display("FAIL t2_cpu_rdata c=%0d got=%h", c, cpu_rdata); end
                checks++; if (dma_rdata !== (prev_dma ? 32'h55AA55AA : 32'h0)) begin errors++; $display("FAIL t2_dma_rdata c=%0d got=%h", c, dma_rdata); end
            end
            prev_dma = exp_dma;
        end
    endtask

    task automatic test_dma_byte_write();
        step();
        dma_memwrite = 1; dma_addr = 32'h1003; dma_wdata = 32'h000000AB; dma_sign_mask = 4'b0001;
        #1;
        checks++; if ({dma_gnt, mem_memwrite, mem_memread} !== 3'b110) begin errors++; $display("FAIL t3_gnt got=%b exp=110", {dma_gnt, mem_memwrite, mem_memread}); end
        checks++; if ({mem_wdata, mem_sign_mask} !== {32'hAB, 4'b0001}) begin errors++; $display("FAIL t3_mux got=%h/%b exp=000000ab/0001", mem_wdata, mem_sign_mask); end
        step();
        idle();
        cpu_memread = 1; cpu_addr = 32'h1000; cpu_sign_mask = 4'b0111;
        #1;
        checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL t3_no_rvalid got=%b exp=0", dma_rvalid); end
        step();
        idle();
        #1;
        checks++; if ({cpu_rvalid, cpu_rdata} !== {1'b1, 32'hABADBEEF}) begin errors++; $display("FAIL t3_readback got=%b/%h exp=1/abadbeef", cpu_rvalid, cpu_rdata); end
    endtask

    task automatic test_back_to_back();
        step();
        cpu_memwrite = 1; cpu_addr = 32'h1010; cpu_wdata = 32'hCAFEF00D; cpu_sign_mask = 4'b0111;
        #1;
        checks++; if ({cpu_stall, mem_memwrite} !== 2'b01) begin errors++; $display("FAIL t4_write got=%b exp=01", {cpu_stall, mem_memwrite}); end
        step();
        idle();
        dma_memread = 1; dma_addr = 32'h1010; dma_sign_mask = 4'b0111;
        #1;
        checks++; if ({cpu_rvalid, dma_rvalid, dma_gnt} !== 3'b001) begin errors++; $display("FAIL t4_cycle1 got=%b exp=001", {cpu_rvalid, dma_rvalid, dma_gnt}); end
        step();
        idle();
        #1;
        checks++; if ({dma_rvalid, dma_rdata} !== {1'b1, 32'hCAFEF00D}) begin errors++; $display("FAIL t4_dma_read got=%b/%h exp=1/cafef00d", dma_rvalid, dma_rdata); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL t4_cpu_rdata got=%h exp=0", cpu_rdata); end
        checks++; if (dut.wait_cnt !== '0) begin errors++; $display("FAIL t4_wait_cnt got=%0d exp=0", dut.wait_cnt); end
    endtask

    task automatic test_read_write_both();
        step();
        cpu_memread = 1; cpu_memwrite = 1; cpu_addr = 32'h1004; cpu_wdata = 32'hFFFFFFFF; cpu_sign_mask = 4'b0111;
        #1;
        checks++; if ({mem_memread, mem_memwrite} !== 2'b10) begin errors++; $display("FAIL t6_rw got=%b exp=10", {mem_memread, mem_memwrite}); end
        step();
        idle();
        #1;
        checks++; if ({cpu_rvalid, cpu_rdata} !== {1'b1, 32'h11223344}) begin errors++; $display("FAIL t6_read got=%b/%h exp=1/11223344", cpu_rvalid, cpu_rdata); end
        checks++; if (mem[12'h401] !== 32'h11223344) begin errors++; $display("FAIL t6_unchanged got=%h exp=11223344", mem[12'h401]); end
    endtask

    task automatic test_reset_mid_read();
        step();
        cpu_memread = 1; cpu_addr = 32'h1000; cpu_sign_mask = 4'b0111;
        #1;
        checks++; if (mem_memread !== 1'b1) begin errors++; $display("FAIL t5_pre_gnt got=%b exp=1", mem_memread); end
        rst_n = 0;
        #1;
        checks++; if ({mem_memread, cpu_stall, dma_gnt} !== 3'b000) begin errors++; $display("FAIL t5_forced got=%b exp=000", {mem_memread, cpu_stall, dma_gnt}); end
        step();
        #1;
        checks++; if ({cpu_rvalid, mem_memread, cpu_stall} !== 3'b000) begin errors++; $display("FAIL t5_in_reset got=%b exp=000", {cpu_rvalid, mem_memread, cpu_stall}); end
        step();
        idle();
        dma_memread = 1; dma_addr = 32'h1008; dma_sign_mask = 4'b0111;
        rst_n = 1;
        #1;
        checks++; if ({dma_gnt, cpu_rvalid, mem_addr} !== {2'b10, 32'h1008}) begin errors++; $display("FAIL t5_release got=%b/%h exp=10/00001008", {dma_gnt, cpu_rvalid}, mem_addr); end
        step();
        idle();
        #1;
        checks++; if ({dma_rvalid, dma_rdata, cpu_rvalid} !== {1'b1, 32'h55AA55AA, 1'b0}) begin errors++; $display("FAIL t5_dma_read got=%b/%h/%b exp=1/55aa55aa/0", dma_rvalid, dma_rdata, cpu_rvalid); end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_starvation();
        test_dma_byte_write();
        test_back_to_back();
        test_read_write_both();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
